// File: rtl/mem_port_arbiter.sv
// Two-requester (icache/dcache) arbiter for a single shared memory port.
// One transaction in flight, round-robin on ties, sticky response-timeout flag.
package mem_port_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memory_io_req32;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
    } memory_io_rsp32;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  memory_io_req32 icache_req,
    output memory_io_rsp32 icache_rsp,
    input  memory_io_req32 dcache_req,
    output memory_io_rsp32 dcache_rsp,
    output memory_io_req32 mem_req,
    input  memory_io_rsp32 mem_rsp,
    output logic           busy,
    output logic           timeout_err
);
    typedef enum logic [1:0] {IDLE, WAIT_RSP, DRAIN} state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic           owner_ic_q, owner_ic_d;   // 1: icache owns the transaction
    logic           last_ic_q, last_ic_d;     // 1: icache was granted last
    logic [31:0]    pend_addr_q, pend_addr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           terr_q, terr_d;
    memory_io_req32 mem_req_q, mem_req_d;
    memory_io_rsp32 icache_rsp_q, icache_rsp_d;
    memory_io_rsp32 dcache_rsp_q, dcache_rsp_d;

    logic           grant_ic;
    logic           rsp_match;
    memory_io_rsp32 rsp_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_ic_q   <= 1'b0;
            last_ic_q    <= 1'b1;
            pend_addr_q  <= '0;
            cnt_q        <= '0;
            terr_q       <= 1'b0;
            mem_req_q    <= '0;
            icache_rsp_q <= '0;
            dcache_rsp_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_ic_q   <= owner_ic_d;
            last_ic_q    <= last_ic_d;
            pend_addr_q  <= pend_addr_d;
            cnt_q        <= cnt_d;
            terr_q       <= terr_d;
            mem_req_q    <= mem_req_d;
            icache_rsp_q <= icache_rsp_d;
            dcache_rsp_q <= dcache_rsp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_ic_d   = owner_ic_q;
        last_ic_d    = last_ic_q;
        pend_addr_d  = pend_addr_q;
        cnt_d        = cnt_q;
        terr_d       = terr_q;
        mem_req_d    = '0;
        icache_rsp_d = '0;
        dcache_rsp_d = '0;
        rsp_out      = '0;
        grant_ic     = icache_req.valid && (!dcache_req.valid || !last_ic_q);
        rsp_match    = mem_rsp.valid && (mem_rsp.addr == pend_addr_q);

        case (state_q)
            IDLE: begin
                if (icache_req.valid || dcache_req.valid) begin
                    mem_req_d       = grant_ic ? icache_req : dcache_req;
                    mem_req_d.valid = 1'b1;
                    pend_addr_d     = grant_ic ? icache_req.addr : dcache_req.addr;
                    owner_ic_d      = grant_ic;
                    last_ic_d       = grant_ic;
                    cnt_d           = '0;
                    state_d         = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A matching response wins over a timeout landing in the same cycle
                if (rsp_match || cnt_q == TO_LAST) begin
                    rsp_out.valid = 1'b1;
                    rsp_out.addr  = pend_addr_q;
                    rsp_out.data  = rsp_match ? mem_rsp.data : 32'h0;
                    terr_d        = terr_q | !rsp_match;
                    state_d       = DRAIN;
                    if (owner_ic_q) icache_rsp_d = rsp_out;
                    else            dcache_rsp_d = rsp_out;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req     = mem_req_q;
    assign icache_rsp  = icache_rsp_q;
    assign dcache_rsp  = dcache_rsp_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES=8; inputs change #1
// after a rising edge, outputs are checked in the same window.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    memory_io_req32 icache_req, dcache_req, mem_req;
    memory_io_rsp32 icache_rsp, dcache_rsp, mem_rsp;
    logic           busy, timeout_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .icache_req (icache_req),
        .icache_rsp (icache_rsp),
        .dcache_req (dcache_req),
        .dcache_rsp (dcache_rsp),
        .mem_req    (mem_req),
        .mem_rsp    (mem_rsp),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    localparam memory_io_rsp32 RSP0 = '0;
    localparam memory_io_req32 REQ0 = '0;

    function automatic memory_io_req32 mkreq(input logic we, input logic [31:0] a, input logic [31:0] d);
        memory_io_req32 r;
        r.valid = 1'b1; r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic memory_io_rsp32 mkrsp(input logic [31:0] a, input logic [31:0] d);
        memory_io_rsp32 r;
        r.valid = 1'b1; r.addr = a; r.data = d;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input memory_io_req32 obs, input memory_io_req32 exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input memory_io_rsp32 obs, input memory_io_rsp32 exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        icache_req = '0;
        dcache_req = '0;
        mem_rsp    = '0;
        step();
        step();
        chk_bit("rst_busy", busy, 1'b0);
        chk_req("rst_mem_req", mem_req, REQ0);
        chk_rsp("rst_icache_rsp", icache_rsp, RSP0);
        chk_rsp("rst_dcache_rsp", dcache_rsp, RSP0);
        chk_bit("rst_terr", timeout_err, 1'b0);
        reset = 1'b0;

        // single icache read, response two cycles after the mem_req cycle
        icache_req = mkreq(1'b0, 32'h100, 32'h0);
        step();
        chk_req("t1_mem_req", mem_req, mkreq(1'b0, 32'h100, 32'h0));
        chk_bit("t1_busy", busy, 1'b1);
        step();
        chk_req("t1_mem_req_pulse", mem_req, REQ0);
        step();
        mem_rsp = mkrsp(32'h100, 32'hDEADBEEF);
        step();
        mem_rsp = '0;
        chk_rsp("t1_icache_rsp", icache_rsp, mkrsp(32'h100, 32'hDEADBEEF));
        chk_rsp("t1_dcache_rsp", dcache_rsp, RSP0);
        icache_req.valid = 1'b0;
        step();
        chk_rsp("t1_icache_rsp_clr", icache_rsp, RSP0);
        chk_bit("t1_idle", busy, 1'b0);

        // tie straight after reset: dcache first, then a repeat tie goes to icache
        reset = 1'b1;
        step();
        reset = 1'b0;
        icache_req = mkreq(1'b0, 32'h200, 32'h0);
        dcache_req = mkreq(1'b1, 32'h300, 32'h55);
        step();
        chk_req("t2_grant_d", mem_req, mkreq(1'b1, 32'h300, 32'h55));
        mem_rsp = mkrsp(32'h300, 32'h33);
        step();
        mem_rsp = '0;
        chk_rsp("t2_dcache_rsp", dcache_rsp, mkrsp(32'h300, 32'h33));
        chk_rsp("t2_icache_quiet", icache_rsp, RSP0);
        dcache_req = mkreq(1'b0, 32'h304, 32'h0);
        step();
        chk_bit("t2_idle", busy, 1'b0);
        step();
        chk_req("t2_grant_i", mem_req, mkreq(1'b0, 32'h200, 32'h0));
        mem_rsp = mkrsp(32'h200, 32'h22);
        step();
        mem_rsp = '0;
        chk_rsp("t2_icache_rsp", icache_rsp, mkrsp(32'h200, 32'h22));
        icache_req.valid = 1'b0;
        step();
        step();
        chk_req("t2_grant_d2", mem_req, mkreq(1'b0, 32'h304, 32'h0));
        mem_rsp = mkrsp(32'h304, 32'h44);
        step();
        mem_rsp = '0;
        chk_rsp("t2_dcache_rsp2", dcache_rsp, mkrsp(32'h304, 32'h44));
        dcache_req.valid = 1'b0;
        step();

        // mismatched response address is ignored
        icache_req = mkreq(1'b0, 32'h400, 32'h0);
        step();
        chk_req("t3_mem_req", mem_req, mkreq(1'b0, 32'h400, 32'h0));
        mem_rsp = mkrsp(32'h404, 32'hBAD);
        step();
        mem_rsp = mkrsp(32'h400, 32'h600D);
        chk_rsp("t3_ignored", icache_rsp, RSP0);
        chk_bit("t3_busy", busy, 1'b1);
        step();
        mem_rsp = '0;
        chk_rsp("t3_icache_rsp", icache_rsp, mkrsp(32'h400, 32'h600D));
        icache_req.valid = 1'b0;
        step();

        // timeout: rsp 8 cycles after mem_req cycle; a stray mismatch must not restart the count
        dcache_req = mkreq(1'b0, 32'h500, 32'h0);
        step();
        chk_req("t4_mem_req", mem_req, mkreq(1'b0, 32'h500, 32'h0));
        for (int i = 1; i <= 7; i++) begin
            mem_rsp = (i == 3) ? mkrsp(32'h504, 32'h1) : RSP0;
            step();
            chk_bit("t4_no_rsp", dcache_rsp.valid, 1'b0);
        end
        mem_rsp = '0;
        step();
        chk_rsp("t4_timeout_rsp", dcache_rsp, mkrsp(32'h500, 32'h0));
        chk_bit("t4_terr", timeout_err, 1'b1);
        dcache_req.valid = 1'b0;
        step();
        step();
        chk_bit("t4_terr_sticky", timeout_err, 1'b1);
        chk_rsp("t4_rsp_clr", dcache_rsp, RSP0);

        // matching response in the timeout cycle wins
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_bit("t5_terr_reset", timeout_err, 1'b0);
        icache_req = mkreq(1'b0, 32'h600, 32'h0);
        step();
        for (int i = 1; i <= 7; i++) step();
        chk_rsp("t5_no_rsp_yet", icache_rsp, RSP0);
        mem_rsp = mkrsp(32'h600, 32'hCAFE);
        step();
        mem_rsp = '0;
        chk_rsp("t5_icache_rsp", icache_rsp, mkrsp(32'h600, 32'hCAFE));
        chk_bit("t5_terr", timeout_err, 1'b0);
        icache_req.valid = 1'b0;
        step();

        // reset mid-transaction, then a late response
        dcache_req = mkreq(1'b0, 32'h700, 32'h0);
        step();
        chk_bit("t6_busy", busy, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        dcache_req.valid = 1'b0;
        chk_bit("t6_busy_rst", busy, 1'b0);
        mem_rsp = mkrsp(32'h700, 32'h77);
        step();
        mem_rsp = '0;
        chk_rsp("t6_dcache_rsp", dcache_rsp, RSP0);
        step();
        chk_rsp("t6_dcache_rsp2", dcache_rsp, RSP0);
        chk_rsp("t6_icache_rsp", icache_rsp, RSP0);
        chk_bit("t6_idle", busy, 1'b0);
        chk_req("t6_mem_req", mem_req, REQ0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
